// File: rtl/game_pkg.sv
// Shared playfield constants, coordinate types and flight-state encoding used by
// the aim block, the shot tracer and the renderer.
package game_pkg;

  localparam int XW    = 5;
  localparam int YW    = 5;
  localparam int SW    = 5;
  localparam int ERR_W = 8;

  typedef logic [XW-1:0]           x_t;
  typedef logic [YW-1:0]           y_t;
  typedef logic [SW-1:0]           slope_t;
  typedef logic signed [ERR_W-1:0] err_t;

  localparam x_t X_MAX = x_t'(2**XW - 1);
  localparam y_t Y_MAX = y_t'(2**YW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/traj_step.sv
// One combinational Bresenham step of the projectile, including the side-wall
// bounce; the caller decides when to register the result.
module traj_step
  import game_pkg::*;
(
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic [ERR_W-1:0] err,
  input  logic             dir,
  input  logic [SW-1:0]    run,
  input  logic [SW-1:0]    rise,
  output logic [XW-1:0]    x_n,
  output logic [YW-1:0]    y_n,
  output logic [ERR_W-1:0] err_n,
  output logic             dir_n
);

  err_t run_s;
  err_t rise_s;
  err_t e_acc;
  err_t e_dbl;
  logic steep;
  logic move_x;

  // NOTE: every output gets a default before any branch, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    run_s  = err_t'({{(ERR_W-SW){1'b0}}, run});
    rise_s = err_t'({{(ERR_W-SW){1'b0}}, rise});
    steep  = (rise >= run);
    e_acc  = err_t'(err) + (steep ? run_s : rise_s);
    e_dbl  = e_acc <<< 1;
    y_n    = y;
    err_n  = e_acc;
    move_x = 1'b0;

    if (steep) begin
      y_n = y + y_t'(1);
      if (e_dbl >= rise_s) begin
        move_x = 1'b1;
        err_n  = e_acc - rise_s;
      end
    end else begin
      move_x = 1'b1;
      if (e_dbl >= run_s) begin
        y_n   = y + y_t'(1);
        err_n = e_acc - run_s;
      end
    end

    // A move into a wall spends the step turning around instead of moving.
    x_n   = x;
    dir_n = dir;
    if (move_x) begin
      if (dir) begin
        if (x == X_MAX) dir_n = 1'b0;
        else            x_n   = x + x_t'(1);
      end else begin
        if (x == '0)    dir_n = 1'b1;
        else            x_n   = x - x_t'(1);
      end
    end
  end

endmodule

// File: rtl/shot_tracer.sv
// Launches a projectile on fire, walks it up the playfield one step per tick,
// and pulses done/hit one cycle after it reaches the top row.
module shot_tracer
  import game_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          fire,
  input  logic [XW-1:0] x_pos,
  input  logic [SW-1:0] run,
  input  logic [SW-1:0] rise,
  input  logic          dir,
  input  logic [XW-1:0] tgt_x,
  output logic [XW-1:0] proj_x,
  output logic [YW-1:0] proj_y,
  output logic          proj_dir,
  output logic          active,
  output logic          done,
  output logic          hit
);

  state_e state, state_n;
  err_t   err, err_n;
  slope_t run_q, run_n;
  slope_t rise_q, rise_n;
  x_t     x_n, step_x;
  y_t     y_n, step_y;
  err_t   step_err;
  logic   dir_n, step_dir;
  logic   active_n, done_n, hit_n;

  traj_step u_step (
    .x     (proj_x),
    .y     (proj_y),
    .err   (err),
    .dir   (proj_dir),
    .run   (run_q),
    .rise  (rise_q),
    .x_n   (step_x),
    .y_n   (step_y),
    .err_n (step_err),
    .dir_n (step_dir)
  );

  always_comb begin
    state_n = state;
    x_n     = proj_x;
    y_n     = proj_y;
    dir_n   = proj_dir;
    err_n   = err;
    run_n   = run_q;
    rise_n  = rise_q;
    done_n  = 1'b0;
    hit_n   = 1'b0;

    case (state)
      IDLE: begin
        // A zero rise would never reach the top row, so such a launch is dropped.
        if (fire && (rise != '0)) begin
          state_n = FLY;
          x_n     = x_pos;
          y_n     = '0;
          dir_n   = dir;
          err_n   = '0;
          run_n   = run;
          rise_n  = rise;
        end
      end
      FLY: begin
        if (tick) begin
          x_n   = step_x;
          y_n   = step_y;
          dir_n = step_dir;
          err_n = step_err;
          if (step_y == Y_MAX) state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        done_n  = 1'b1;
        hit_n   = (proj_x == tgt_x);
      end
      default: state_n = IDLE;
    endcase

    active_n = (state_n == FLY);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      proj_x   <= '0;
      proj_y   <= '0;
      proj_dir <= 1'b0;
      err      <= '0;
      run_q    <= '0;
      rise_q   <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
      hit      <= 1'b0;
    end else begin
      state    <= state_n;
      proj_x   <= x_n;
      proj_y   <= y_n;
      proj_dir <= dir_n;
      err      <= err_n;
      run_q    <= run_n;
      rise_q   <= rise_n;
      active   <= active_n;
      done     <= done_n;
      hit      <= hit_n;
    end
  end

endmodule

// File: tb/tb_shot_tracer.sv
// Bench for shot_tracer: closed-form flight model compared every cycle, plus
// directed shots with hand-computed positions and randomized launches/ticks.
module tb_shot_tracer;
  import game_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic          fire = 1'b0;
  logic          dir = 1'b0;
  logic [XW-1:0] x_pos = '0;
  logic [XW-1:0] tgt_x = '0;
  logic [SW-1:0] run = '0;
  logic [SW-1:0] rise = '0;
  logic [XW-1:0] proj_x;
  logic [YW-1:0] proj_y;
  logic          proj_dir, active, done, hit;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  shot_tracer dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .fire     (fire),
    .x_pos    (x_pos),
    .run      (run),
    .rise     (rise),
    .dir      (dir),
    .tgt_x    (tgt_x),
    .proj_x   (proj_x),
    .proj_y   (proj_y),
    .proj_dir (proj_dir),
    .active   (active),
    .done     (done),
    .hit      (hit)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ideal line rounded to nearest: after t ticks, horizontal moves and rows climbed.
  function automatic int moves_at(int t, int r, int q);
    if (q >= r) return (2 * t * r + q) / (2 * q);
    return t;
  endfunction

  function automatic int rows_at(int t, int r, int q);
    if (q >= r) return t;
    return (2 * t * q + r) / (2 * r);
  endfunction

  // Walls unfold into a ring of 2*(X_MAX+1) slots; the first half moves right.
  function automatic int unfold(int x0, int moves, bit d0);
    int period = 2 * (int'(X_MAX) + 1);
    return ((d0 ? x0 : period - 1 - x0) + moves) % period;
  endfunction

  function automatic int x_at(int x0, int moves, bit d0);
    int u = unfold(x0, moves, d0);
    return (u <= int'(X_MAX)) ? u : 2 * int'(X_MAX) + 1 - u;
  endfunction

  function automatic bit dir_at(int x0, int moves, bit d0);
    return unfold(x0, moves, d0) <= int'(X_MAX);
  endfunction

  bit m_fly, m_finish, m_done, m_hit, m_dir, m_d0;
  int m_t, m_x0, m_run, m_rise, m_x, m_y;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fly <= 0; m_finish <= 0; m_done <= 0; m_hit <= 0; m_dir <= 0; m_d0 <= 0;
      m_t <= 0; m_x0 <= 0; m_run <= 0; m_rise <= 0; m_x <= 0; m_y <= 0;
    end else begin
      m_done <= 0;
      m_hit  <= 0;
      if (m_finish) begin
        m_finish <= 0;
        m_done   <= 1;
        m_hit    <= (m_x == int'(tgt_x));
      end else if (m_fly) begin
        if (tick) begin
          m_t   <= m_t + 1;
          m_x   <= x_at(m_x0, moves_at(m_t + 1, m_run, m_rise), m_d0);
          m_dir <= dir_at(m_x0, moves_at(m_t + 1, m_run, m_rise), m_d0);
          m_y   <= rows_at(m_t + 1, m_run, m_rise);
          if (rows_at(m_t + 1, m_run, m_rise) == int'(Y_MAX)) begin
            m_fly    <= 0;
            m_finish <= 1;
          end
        end
      end else if (fire && rise != 0) begin
        m_x0 <= int'(x_pos); m_d0 <= dir; m_run <= int'(run); m_rise <= int'(rise);
        m_t <= 0; m_x <= int'(x_pos); m_y <= 0; m_dir <= dir; m_fly <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("active", active, m_fly);
      check("done", done, m_done);
      check("proj_x", proj_x, m_x);
      check("proj_y", proj_y, m_y);
      check("proj_dir", proj_dir, m_dir);
      if (m_done) check("hit", hit, m_hit);
    end
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int x, input int r, input int q, input bit d);
    x_pos = XW'(x); run = SW'(r); rise = SW'(q); dir = d;
    fire = 1'b1;
    step_cycle();
    fire = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step_cycle();
      tick = 1'b0;
      if ($urandom_range(0, 1) == 1) step_cycle();
    end
  endtask

  task automatic wait_done(input int bound);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      if (done) got = 1'b1;
      else step_cycle();
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic run_to_done(input int max_ticks);
    bit got = 1'b0;
    for (int i = 0; i < max_ticks && !got; i++) begin
      tick = 1'b1;
      step_cycle();
      tick = 1'b0;
      step_cycle();
      if (done) got = 1'b1;
    end
    if (!got) check("run_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step_cycle();
    cmp_en = 1'b1;
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_x", proj_x, 0);
    check("rst_y", proj_y, 0);
    reset = 1'b1;
    step_cycle();

    // Vertical shot with exact done timing.
    tgt_x = 5'd10;
    launch(10, 0, 5, 1);
    check("vert_active", active, 1);
    check("vert_y0", proj_y, 0);
    ticks(30);
    check("vert_x30", proj_x, 10);
    check("vert_y30", proj_y, 30);
    tick = 1'b1;
    step_cycle();
    tick = 1'b0;
    check("vert_y31", proj_y, 31);
    check("vert_done_early", done, 0);
    step_cycle();
    check("vert_done", done, 1);
    check("vert_hit", hit, 1);
    step_cycle();
    check("vert_done_once", done, 0);

    tgt_x = 5'd11;
    launch(10, 0, 5, 1);
    run_to_done(40);
    check("vert_miss", hit, 0);
    step_cycle();

    // Diagonal.
    launch(0, 4, 4, 1);
    ticks(31);
    wait_done(4);
    check("diag_x", proj_x, 31);
    check("diag_y", proj_y, 31);
    check("diag_dir", proj_dir, 1);
    step_cycle();

    // Bounce off the right wall.
    launch(28, 4, 4, 1);
    ticks(3);
    check("bnc_x3", proj_x, 31);
    check("bnc_y3", proj_y, 3);
    ticks(1);
    check("bnc_x4", proj_x, 31);
    check("bnc_y4", proj_y, 4);
    check("bnc_dir4", proj_dir, 0);
    ticks(27);
    wait_done(4);
    check("bnc_xf", proj_x, 4);
    check("bnc_yf", proj_y, 31);
    step_cycle();

    // Shallow slope.
    launch(0, 8, 2, 1);
    ticks(6);
    check("shal_x6", proj_x, 6);
    check("shal_y6", proj_y, 2);
    run_to_done(200);
    step_cycle();

    // Rejected launch, then fire+tick priority and fire during flight.
    launch(3, 2, 0, 1);
    check("rej_active", active, 0);
    step_cycle();
    check("rej_active2", active, 0);
    tick = 1'b1;
    launch(5, 4, 4, 1);
    tick = 1'b0;
    check("prio_x", proj_x, 5);
    check("prio_y", proj_y, 0);
    x_pos = 5'd20; run = 5'd0; rise = 5'd7; dir = 1'b0;
    fire = 1'b1; tick = 1'b1;
    step_cycle();
    fire = 1'b0; tick = 1'b0;
    check("fly_fire_x", proj_x, 6);
    check("fly_fire_y", proj_y, 1);
    check("fly_fire_dir", proj_dir, 1);
    run_to_done(40);
    step_cycle();

    // Reset mid-flight.
    tgt_x = 5'd10;
    launch(10, 0, 5, 1);
    ticks(10);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_active", active, 0);
    check("mid_rst_x", proj_x, 0);
    check("mid_rst_y", proj_y, 0);
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      check("mid_rst_done", done, 0);
    end
    reset = 1'b1;
    step_cycle();
    launch(12, 3, 9, 0);
    check("relaunch_x", proj_x, 12);
    check("relaunch_y", proj_y, 0);
    check("relaunch_dir", proj_dir, 0);
    ticks(3);
    check("relaunch_x3", proj_x, 11);
    check("relaunch_y3", proj_y, 3);
    run_to_done(40);
    step_cycle();

    // Randomized launches, ticks and stray fires.
    for (int c = 0; c < 6000; c++) begin
      tick = ($urandom_range(0, 1) == 1);
      fire = ($urandom_range(0, 7) == 0);
      x_pos = XW'($urandom_range(0, 31));
      run   = SW'($urandom_range(0, 31));
      rise  = ($urandom_range(0, 5) == 0) ? '0 : SW'($urandom_range(1, 31));
      dir   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) tgt_x = XW'($urandom_range(0, 31));
      step_cycle();
    end
    fire = 1'b0;
    tick = 1'b0;
    repeat (4) step_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shot_tracer.md
Name: shot_tracer

Overview:
- Consumer of the aim interface produced by the player position/aim block.
- On a fire strobe it latches the launch column x_pos and the aim slope (run, rise, dir), then walks a projectile up a 32x32 playfield with an integer Bresenham stepper, one pixel per tick.
- Side walls reflect the projectile; it terminates at the top row and reports hit/miss against a target column.
- Feeds the renderer (projectile coordinates) and the score logic (done/hit).

Parameters:
- XW, 5, width of x coordinates; X_MAX = 2**XW-1
- YW, 5, width of y coordinates; Y_MAX = 2**YW-1
- SW, 5, width of run/rise slope terms

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  step strobe, one cycle wide; one projectile step per strobe
- fire  in  1  launch request, sampled only in IDLE
- x_pos  in  XW  launch column
- run  in  SW  horizontal slope term (dx)
- rise  in  SW  vertical slope term (dy)
- dir  in  1  initial horizontal direction, 1 = right (x increasing)
- tgt_x  in  XW  target column, compared at termination
- proj_x  out  XW  projectile column
- proj_y  out  YW  projectile row, 0 = launch row
- proj_dir  out  1  current horizontal direction after bounces
- active  out  1  high while the projectile is in flight
- done  out  1  one-cycle pulse when the flight terminates
- hit  out  1  valid only with done: 1 when proj_x == tgt_x

Behaviour:
- Reset: all outputs 0, state IDLE, err 0, latched slope 0. Reset mid-flight aborts immediately with no done pulse.
- States and transitions:
  - IDLE -> FLY when fire=1 and rise != 0. Latch run, rise and dir; set proj_x = x_pos, proj_y = 0, err = 0. active goes 1 on the next cycle.
  - A fire with rise == 0 is ignored and the block stays in IDLE.
  - In IDLE, fire has priority over tick; tick is ignored.
  - FLY: on each tick, apply one step; see below.
  - FLY -> DONE on the step that makes proj_y == Y_MAX.
  - DONE lasts exactly 1 cycle: done = 1, hit = (proj_x == tgt_x), active = 0; then -> IDLE.
  - fire and tick are ignored in FLY and DONE. proj_x and proj_y hold their last values in IDLE.
- Step arithmetic: err is signed, 8 bits wide; the comparison uses 2*e at 8 bits; no overflow for SW = 5.
  - Steep mode (rise >= run): y += 1. e = err + run. If 2*e >= rise, request an x move and e -= rise. err <= e.
  - Shallow mode (run > rise): request an x move. e = err + rise. If 2*e >= run, y += 1 and e -= run. err <= e.
  - run == 0 selects steep mode, giving a pure vertical flight.
- x move and wall bounce:
  - dir=1 and proj_x < X_MAX: x+1. dir=0 and proj_x > 0: x-1.
  - At a wall (x == X_MAX moving right, or x == 0 moving left): toggle proj_dir and leave x unchanged. The y update and err update for that step still apply.
- Timing: outputs are registered. Step results are visible the cycle after the tick. done follows the terminating tick by 2 cycles: FLY step applied, then DONE.

Decomposition:
- Shared package game_pkg holds:
  - XW, YW, SW, X_MAX, Y_MAX constants
  - state enum {IDLE, FLY, DONE}
  - coordinate typedefs
  These are shared with the aim block and the renderer.
- One sub-module, traj_step: purely combinational next-state step. Inputs: x, y, err, dir, run, rise. Outputs: x_n, y_n, err_n, dir_n. The top level holds the FSM and registers.

Test Plan:
- Vertical shot: x_pos=10, run=0, rise=5, fire, then 31 ticks -> proj_x=10 throughout, proj_y=31; done pulse 2 cycles after tick 31; with tgt_x=10 -> hit=1; with tgt_x=11 -> hit=0.
- Diagonal: x_pos=0, run=4, rise=4, dir=1, 31 ticks -> x and y both +1 every tick; final (31,31), done=1, proj_dir=1.
- Bounce: x_pos=28, run=4, rise=4, dir=1 -> after tick 3 the position is (31,3). Tick 4 gives (31,4) with proj_dir=0. Final after 31 ticks: (4,31).
- Shallow slope: x_pos=0, run=8, rise=2, dir=1 -> y increments on ticks 2, 6, 10, ...; after 6 ticks the position is (6,2); proj_y never skips a value.
- Rejects and priority:
  - fire with rise=0 -> active stays 0.
  - fire+tick in the same cycle in IDLE -> position (x_pos,0) and no step.
  - fire during FLY -> latched slope unchanged.
- Reset mid-flight: drop reset at tick 10 of a vertical shot -> all outputs 0 asynchronously, no done pulse; a subsequent fire launches cleanly from y=0.
